// File: rtl/sisc_fetch.sv
// SISC instruction fetch: PC, req/ack word fetch into IR, absolute or relative branches.
// Optional feature macro: SISC_BR_REL_EN (PC-relative branch targets via i_br_rel/i_br_off).
module sisc_fetch #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_f,
    input  logic            i_fetch_en,
    input  logic            i_br_take,
    input  logic [PC_W-1:0] i_br_addr,
    input  logic            i_br_rel,
    input  logic [15:0]     i_br_off,
    input  logic            i_mem_ack,
    input  logic [31:0]     i_mem_rdata,
    output logic            o_mem_req,
    output logic [PC_W-1:0] o_mem_addr,
    output logic [31:0]     o_ir,
    output logic            o_ir_valid,
    output logic [PC_W-1:0] o_pc,
    output logic            o_busy
);

    // state  | meaning
    // S_IDLE | waiting for fetch_en; branches load pc directly
    // S_REQ  | mem_req high, waiting for mem_ack; branches are deferred
    // S_DONE | ir just loaded, ir_valid pulse
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_br_pend;
    logic [PC_W-1:0] r_br_tgt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_tgt;

    assign w_pc_inc = r_pc + PC_W'(1);

`ifdef SISC_BR_REL_EN
    logic [PC_W-1:0] w_off_ext;
    generate
        if (PC_W > 16) begin : g_off_sext
            assign w_off_ext = {{(PC_W-16){i_br_off[15]}}, i_br_off};
        end else begin : g_off_trunc
            assign w_off_ext = i_br_off[PC_W-1:0];
        end
    endgenerate
    assign w_tgt = i_br_rel ? (w_pc_inc + w_off_ext) : i_br_addr;
`else
    logic w_unused_rel;
    assign w_unused_rel = ^{i_br_rel, i_br_off};
    assign w_tgt = i_br_addr;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            // A branch in the same cycle as fetch_en wins; the fetch starts a cycle later.
            S_IDLE:  if (i_fetch_en && !i_br_take) w_next = S_REQ;
            S_REQ:   if (i_mem_ack) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_f) begin
        if (!i_rst_f) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_br_pend <= 1'b0;
            r_br_tgt  <= RESET_PC;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_REQ: begin
                    if (i_br_take) begin
                        r_br_pend <= 1'b1;
                        r_br_tgt  <= w_tgt;
                    end
                    if (i_mem_ack) begin
                        r_ir      <= i_mem_rdata;
                        r_br_pend <= 1'b0;
                        // A branch arriving on the ack edge itself is the latest one.
                        if (i_br_take)      r_pc <= w_tgt;
                        else if (r_br_pend) r_pc <= r_br_tgt;
                        else                r_pc <= w_pc_inc;
                    end
                end
                default: begin
                    if (i_br_take) r_pc <= w_tgt;
                end
            endcase
        end
    end

    assign o_mem_req  = (r_state == S_REQ);
    assign o_mem_addr = r_pc;
    assign o_ir       = r_ir;
    assign o_ir_valid = (r_state == S_DONE);
    assign o_pc       = r_pc;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed bench for sisc_fetch: vector table plus hand sequences for reset, wrap and relative branches.
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        fe, bt, brel, ack;
    logic [15:0] ba, boff;
    logic [31:0] rd;
    logic        req, vld, busy;
    logic [15:0] addr, pc;
    logic [31:0] ir;

    logic        s_fe, s_bt, s_ack;
    logic [3:0]  s_ba;
    logic [31:0] s_rd;
    logic        s_req, s_vld, s_busy;
    logic [3:0]  s_addr, s_pc;
    logic [31:0] s_ir;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sisc_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .i_clk(clk), .i_rst_f(rst_f), .i_fetch_en(fe), .i_br_take(bt),
        .i_br_addr(ba), .i_br_rel(brel), .i_br_off(boff), .i_mem_ack(ack),
        .i_mem_rdata(rd), .o_mem_req(req), .o_mem_addr(addr), .o_ir(ir),
        .o_ir_valid(vld), .o_pc(pc), .o_busy(busy)
    );

    sisc_fetch #(.PC_W(4), .RESET_PC(4'h0)) dut4 (
        .i_clk(clk), .i_rst_f(rst_f), .i_fetch_en(s_fe), .i_br_take(s_bt),
        .i_br_addr(s_ba), .i_br_rel(1'b0), .i_br_off(16'h0000), .i_mem_ack(s_ack),
        .i_mem_rdata(s_rd), .o_mem_req(s_req), .o_mem_addr(s_addr), .o_ir(s_ir),
        .o_ir_valid(s_vld), .o_pc(s_pc), .o_busy(s_busy)
    );

    typedef struct {
        logic        fe, bt;
        logic [15:0] ba;
        logic        ack;
        logic [31:0] rd;
        logic        req;
        logic [15:0] addr;
        logic [31:0] ir;
        logic        vld;
        logic [15:0] pc;
        logic        busy;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic f, input logic b, input logic [15:0] a,
                                input logic k, input logic [31:0] r, input logic e_req,
                                input logic [31:0] e_ir, input logic e_vld,
                                input logic [15:0] e_pc, input logic e_busy);
        vec_t v;
        v.fe = f; v.bt = b; v.ba = a; v.ack = k; v.rd = r;
        v.req = e_req; v.addr = e_pc; v.ir = e_ir; v.vld = e_vld; v.pc = e_pc; v.busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        fe = 1'b0; bt = 1'b0; ba = 16'h0; brel = 1'b0; boff = 16'h0; ack = 1'b0; rd = 32'h0;
        s_fe = 1'b0; s_bt = 1'b0; s_ba = 4'h0; s_ack = 1'b0; s_rd = 32'h0;
    endtask

    initial begin
        logic [15:0] exp_rel;
        //             fe    bt    ba       ack   rdata          req   ir             vld   pc       busy
        vecs[0]  = mk(1'b1, 1'b0, 16'h000, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 16'h000, 1'b1);
        vecs[1]  = mk(1'b0, 1'b0, 16'h000, 1'b1, 32'h12345678,  1'b0, 32'h12345678,  1'b1, 16'h001, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 16'h000, 1'b0, 32'h0,         1'b0, 32'h12345678,  1'b0, 16'h001, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 16'h005, 1'b0, 32'h0,         1'b0, 32'h12345678,  1'b0, 16'h005, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 16'h000, 1'b0, 32'h0,         1'b1, 32'h12345678,  1'b0, 16'h005, 1'b1);
        vecs[5]  = mk(1'b0, 1'b1, 16'h040, 1'b0, 32'h0,         1'b1, 32'h12345678,  1'b0, 16'h005, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 16'h000, 1'b0, 32'h0,         1'b1, 32'h12345678,  1'b0, 16'h005, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 16'h000, 1'b0, 32'h0,         1'b1, 32'h12345678,  1'b0, 16'h005, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 16'h000, 1'b1, 32'hAAAA5555,  1'b0, 32'hAAAA5555,  1'b1, 16'h040, 1'b1);
        vecs[9]  = mk(1'b1, 1'b0, 16'h000, 1'b0, 32'h0,         1'b0, 32'hAAAA5555,  1'b0, 16'h040, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 16'h000, 1'b0, 32'h0,         1'b1, 32'hAAAA5555,  1'b0, 16'h040, 1'b1);
        vecs[11] = mk(1'b1, 1'b0, 16'h000, 1'b1, 32'h0BADF00D,  1'b0, 32'h0BADF00D,  1'b1, 16'h041, 1'b1);
        vecs[12] = mk(1'b1, 1'b0, 16'h000, 1'b0, 32'h0,         1'b0, 32'h0BADF00D,  1'b0, 16'h041, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 16'h100, 1'b0, 32'h0,         1'b0, 32'h0BADF00D,  1'b0, 16'h100, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 16'h000, 1'b0, 32'h0,         1'b1, 32'h0BADF00D,  1'b0, 16'h100, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 16'h000, 1'b1, 32'h00000001,  1'b0, 32'h00000001,  1'b1, 16'h101, 1'b1);
        vecs[16] = mk(1'b0, 1'b0, 16'h000, 1'b1, 32'hFFFFFFFF,  1'b0, 32'h00000001,  1'b0, 16'h101, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 16'h000, 1'b1, 32'hFFFFFFFF,  1'b0, 32'h00000001,  1'b0, 16'h101, 1'b0);
        vecs[18] = mk(1'b1, 1'b0, 16'h000, 1'b0, 32'h0,         1'b1, 32'h00000001,  1'b0, 16'h101, 1'b1);
        vecs[19] = mk(1'b0, 1'b0, 16'h000, 1'b1, 32'h00000002,  1'b0, 32'h00000002,  1'b1, 16'h102, 1'b1);
        vecs[20] = mk(1'b0, 1'b1, 16'h200, 1'b0, 32'h0,         1'b0, 32'h00000002,  1'b0, 16'h200, 1'b0);

        idle_inputs();
        rst_f = 1'b0;
        #2;
        chk("rst_req",   {31'b0, req},  32'h0);
        chk("rst_addr",  {16'b0, addr}, 32'h0);
        chk("rst_ir",    ir,            32'h0);
        chk("rst_valid", {31'b0, vld},  32'h0);
        chk("rst_pc",    {16'b0, pc},   32'h0);
        chk("rst_busy",  {31'b0, busy}, 32'h0);
        step();
        rst_f = 1'b1;

        for (int i = 0; i < 21; i++) begin
            fe = vecs[i].fe; bt = vecs[i].bt; ba = vecs[i].ba; ack = vecs[i].ack; rd = vecs[i].rd;
            step();
            chk($sformatf("v%0d_req", i),   {31'b0, req},  {31'b0, vecs[i].req});
            chk($sformatf("v%0d_addr", i),  {16'b0, addr}, {16'b0, vecs[i].addr});
            chk($sformatf("v%0d_ir", i),    ir,            vecs[i].ir);
            chk($sformatf("v%0d_valid", i), {31'b0, vld},  {31'b0, vecs[i].vld});
            chk($sformatf("v%0d_pc", i),    {16'b0, pc},   {16'b0, vecs[i].pc});
            chk($sformatf("v%0d_busy", i),  {31'b0, busy}, {31'b0, vecs[i].busy});
        end
        idle_inputs();

        // Relative branch in IDLE: pc=10, offset -3 -> 8 (absolute build takes br_addr).
        bt = 1'b1; ba = 16'h000A;
        step();
        chk("rel_setup_pc", {16'b0, pc}, 32'h0000000A);
        bt = 1'b1; brel = 1'b1; boff = 16'hFFFD; ba = 16'h0077;
`ifdef SISC_BR_REL_EN
        exp_rel = 16'h0008;
`else
        exp_rel = 16'h0077;
`endif
        step();
        chk("rel_pc", {16'b0, pc}, {16'b0, exp_rel});
        idle_inputs();

        // Reset mid-REQ with ack still pending.
        fe = 1'b1;
        step();
        chk("pre_rst_req", {31'b0, req}, 32'h1);
        fe = 1'b0;
        #2 rst_f = 1'b0;
        #1;
        chk("mid_rst_req",   {31'b0, req},  32'h0);
        chk("mid_rst_pc",    {16'b0, pc},   32'h0);
        chk("mid_rst_ir",    ir,            32'h0);
        chk("mid_rst_valid", {31'b0, vld},  32'h0);
        chk("mid_rst_busy",  {31'b0, busy}, 32'h0);
        step();
        rst_f = 1'b1;
        ack = 1'b1; rd = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("post_rst_ack%0d_ir", i),    ir,           32'h0);
            chk($sformatf("post_rst_ack%0d_pc", i),    {16'b0, pc},  32'h0);
            chk($sformatf("post_rst_ack%0d_valid", i), {31'b0, vld}, 32'h0);
            chk($sformatf("post_rst_ack%0d_req", i),   {31'b0, req}, 32'h0);
        end
        idle_inputs();

        // PC_W=4 instance: fetch at pc=F wraps pc to 0.
        s_bt = 1'b1; s_ba = 4'hF;
        step();
        chk("w4_br_pc", {28'b0, s_pc}, 32'hF);
        s_bt = 1'b0; s_fe = 1'b1;
        step();
        chk("w4_req",  {31'b0, s_req},  32'h1);
        chk("w4_addr", {28'b0, s_addr}, 32'hF);
        s_fe = 1'b0; s_ack = 1'b1; s_rd = 32'hCAFEBABE;
        step();
        chk("w4_ir",    s_ir,            32'hCAFEBABE);
        chk("w4_pc",    {28'b0, s_pc},   32'h0);
        chk("w4_valid", {31'b0, s_vld},  32'h1);
        s_ack = 1'b0;
        step();
        chk("w4_busy",  {31'b0, s_busy}, 32'h0);
        chk("w4_valid_off", {31'b0, s_vld}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
